uart_fifo_tx: RTL and testbench
===============================

# uart_fifo_tx

Serial UART transmitter that drains the read side of an `async_fifo` in the transmit clock domain. It pops one word per frame using the FIFO's show-ahead read interface (`read_data` valid whenever `!empty`). It drives an 8N1-style asynchronous serial line with parameterized bit time and stop bits. The block sits between the clock-domain-crossing FIFO and the board pin.

## Interface
- `DATA_WIDTH`, 8: bits per frame payload, sent LSB first
- `CLOCKS_PER_BIT`, 868: `clk` cycles per serial bit; must be ≥ 2
- `STOP_BITS`, 1: number of stop bits; legal values 1 or 2
- `clk`  in  1  sole clock; the FIFO's `read_clock`
- `reset_n`  in  1  asynchronous, active-low reset
- `fifo_empty`  in  1  from FIFO `empty`
- `fifo_data`  in  DATA_WIDTH  from FIFO `read_data`; valid when `!fifo_empty`
- `fifo_read_en`  out  1  to FIFO `read_enable`; one-cycle pop strobe
- `tx_enable`  in  1  flow control; low blocks the start of new frames
- `tx`  out  1  serial line; idles high
- `tx_busy`  out  1  high while a frame is on the line

## Operation
- Reset values: `tx`=1, `tx_busy`=0, `fifo_read_en`=0, state `TX_IDLE`, all counters 0.
- FSM states: `TX_IDLE` → `TX_START` → `TX_DATA` → (`TX_PARITY`) → `TX_STOP` → `TX_IDLE` or `TX_START`.
- Pop condition: `pop = tx_enable && !fifo_empty && (state==TX_IDLE || stop_last_cycle)`.
  - `fifo_read_en` equals `pop` combinationally. It is never asserted when `fifo_empty`.
  - On the edge where `pop` is high, `fifo_data` is latched into the shift register and the FSM enters `TX_START`.
- Line level by state: `TX_START` drives 0; `TX_DATA` drives `shift[0]`, with the register shifted right at each bit end; `TX_STOP` drives 1.
- Bit timer counts 0..CLOCKS_PER_BIT-1 and is `$clog2(CLOCKS_PER_BIT)` bits wide. The bit counter counts 0..DATA_WIDTH-1 in `TX_DATA`. The stop counter counts 0..STOP_BITS-1.
- `stop_last_cycle` is the final cycle of the final stop bit.
  - If `pop` is high there, the next frame starts with no idle gap.
  - Otherwise the FSM returns to `TX_IDLE`.
- `tx_enable` falling mid-frame does not truncate the frame; it only suppresses the next `pop`.
- `reset_n` asserted mid-frame: `tx` returns to 1 immediately (asynchronously), the FSM returns to `TX_IDLE`, and the in-flight word is lost.
- `tx_busy` is 1 in every state except `TX_IDLE`.

## Timing
- `pop` at cycle N causes `tx` to fall at N+1; `tx` is registered.
- Frame length is (1 + DATA_WIDTH + P + STOP_BITS) × CLOCKS_PER_BIT cycles, where P=1 with parity and 0 without.
- Back-to-back frames have zero idle cycles between the last stop bit and the next start bit.
- Maximum `pop` rate is one per frame. `fifo_read_en` is never high on two consecutive cycles.
- The `fifo_empty` → `fifo_read_en` path is combinational. The FIFO's `empty` is itself registered-synchronized, so the loop is safe.

## Configuration
- `UART_TX_PARITY_EN` defined: `TX_PARITY` state inserted after `TX_DATA`. It drives even parity, the XOR of the latched word, for one bit time.
- `UART_TX_PARITY_EN` undefined: `TX_PARITY` state and parity logic are absent, and `TX_DATA` goes directly to `TX_STOP`.

## Structure
- Shared package `uart_pkg`: typedef enum `tx_state_t` {TX_IDLE, TX_START, TX_DATA, TX_PARITY, TX_STOP}. The companion receiver reuses the same package.
- No sub-module. The bit timer and counters are inline; the block is a single FSM with three counters and a shift register.

## Test plan
Defaults for all tests: CLOCKS_PER_BIT=4, DATA_WIDTH=8, STOP_BITS=1, no parity unless stated.
- Single word 0xA5 queued, `tx_enable`=1 → one `fifo_read_en` pulse; `tx` = 0,1,0,1,0,0,1,0,1,1 with each bit held 4 cycles; `tx_busy` high exactly 40 cycles.
- 0x00 then 0xFF queued → two pops 40 cycles apart; the stop bit of frame 1 is followed directly by the start bit of frame 2; `tx_busy` high 80 continuous cycles.
- FIFO non-empty with `tx_enable`=0 for 20 cycles → no pop, `tx`=1. Raise `tx_enable` → `fifo_read_en` asserts the same cycle and `tx` falls the next.
- `UART_TX_PARITY_EN`, word 0x07 → parity bit 1 after the data bits; frame length 44 cycles.
- `reset_n` low during data bit 3 → `tx`=1, `tx_busy`=0, `fifo_read_en`=0 at once. After release with the FIFO non-empty, the next word is sent starting from its start bit.
- STOP_BITS=2, word 0x3C → stop level held 8 cycles; total frame 44 cycles.

Source files
------------

// File: rtl/uart_pkg.sv
// Shared UART definitions, used by both the transmitter and the companion receiver.
package uart_pkg;

  typedef enum logic [2:0] {
    TX_IDLE,
    TX_START,
    TX_DATA,
    TX_PARITY,
    TX_STOP
  } tx_state_t;

endpackage

// File: rtl/uart_fifo_tx.sv
// UART transmitter draining the show-ahead read side of an async_fifo.
// Frame: start bit, DATA_WIDTH data bits LSB first, optional even parity, STOP_BITS stop bits.
// Optional feature: define UART_TX_PARITY_EN to insert an even parity bit after the data bits.
module uart_fifo_tx
  import uart_pkg::*;
#(
  parameter int DATA_WIDTH     = 8,
  parameter int CLOCKS_PER_BIT = 868,
  parameter int STOP_BITS      = 1
) (
  input  logic                  clk,
  input  logic                  reset_n,
  input  logic                  fifo_empty,
  input  logic [DATA_WIDTH-1:0] fifo_data,
  output logic                  fifo_read_en,
  input  logic                  tx_enable,
  output logic                  tx,
  output logic                  tx_busy
);

  localparam int TW = $clog2(CLOCKS_PER_BIT);
  localparam int BW = (DATA_WIDTH > 1) ? $clog2(DATA_WIDTH) : 1;
  localparam int SW = 1;
  localparam logic [TW-1:0] TIMER_LAST = TW'(CLOCKS_PER_BIT - 1);
  localparam logic [BW-1:0] BIT_LAST   = BW'(DATA_WIDTH - 1);
  localparam logic [SW-1:0] STOP_LAST  = SW'(STOP_BITS - 1);

  tx_state_t             state_q, state_d;
  logic [TW-1:0]         timer_q, timer_d;
  logic [BW-1:0]         bit_cnt_q, bit_cnt_d;
  logic [SW-1:0]         stop_cnt_q, stop_cnt_d;
  logic [DATA_WIDTH-1:0] shift_q, shift_d;
  logic                  tx_q, tx_d;
  logic                  bit_end;
  logic                  stop_last_cycle;
  logic                  pop;
`ifdef UART_TX_PARITY_EN
  logic                  parity_q, parity_d;
`endif

  assign bit_end         = (timer_q == TIMER_LAST);
  assign stop_last_cycle = (state_q == TX_STOP) && bit_end && (stop_cnt_q == STOP_LAST);
  // Gated by reset_n so no word is popped (and lost) while the block is held in reset.
  assign pop             = reset_n && tx_enable && !fifo_empty &&
                           ((state_q == TX_IDLE) || stop_last_cycle);

  assign fifo_read_en = pop;
  assign tx           = tx_q;
  assign tx_busy      = (state_q != TX_IDLE);

  // Next-state, counter and line-level logic.
  always_comb begin
    state_d    = state_q;
    timer_d    = ((state_q == TX_IDLE) || bit_end) ? '0 : timer_q + TW'(1);
    bit_cnt_d  = bit_cnt_q;
    stop_cnt_d = stop_cnt_q;
    shift_d    = shift_q;
`ifdef UART_TX_PARITY_EN
    parity_d   = parity_q;
    if (pop) parity_d = ^fifo_data;
`endif
    if (pop) shift_d = fifo_data;

    case (state_q)
      TX_IDLE: begin
        if (pop) state_d = TX_START;
      end
      TX_START: begin
        if (bit_end) begin
          state_d   = TX_DATA;
          bit_cnt_d = '0;
        end
      end
      TX_DATA: begin
        if (bit_end) begin
          shift_d = shift_q >> 1;
          if (bit_cnt_q == BIT_LAST) begin
            bit_cnt_d  = '0;
            stop_cnt_d = '0;
`ifdef UART_TX_PARITY_EN
            state_d    = TX_PARITY;
`else
            state_d    = TX_STOP;
`endif
          end else begin
            bit_cnt_d = bit_cnt_q + BW'(1);
          end
        end
      end
`ifdef UART_TX_PARITY_EN
      TX_PARITY: begin
        if (bit_end) begin
          state_d    = TX_STOP;
          stop_cnt_d = '0;
        end
      end
`endif
      TX_STOP: begin
        if (bit_end) begin
          if (stop_cnt_q == STOP_LAST) begin
            stop_cnt_d = '0;
            state_d    = pop ? TX_START : TX_IDLE;
          end else begin
            stop_cnt_d = stop_cnt_q + SW'(1);
          end
        end
      end
      default: state_d = TX_IDLE;
    endcase

    // Line level is decoded from the next state so tx stays a registered output.
    case (state_d)
      TX_START: tx_d = 1'b0;
      TX_DATA:  tx_d = shift_d[0];
`ifdef UART_TX_PARITY_EN
      TX_PARITY: tx_d = parity_d;
`endif
      default:  tx_d = 1'b1;
    endcase
  end

  // State, counters, shift register and line register.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q    <= TX_IDLE;
      timer_q    <= '0;
      bit_cnt_q  <= '0;
      stop_cnt_q <= '0;
      shift_q    <= '0;
      tx_q       <= 1'b1;
`ifdef UART_TX_PARITY_EN
      parity_q   <= 1'b0;
`endif
    end else begin
      state_q    <= state_d;
      timer_q    <= timer_d;
      bit_cnt_q  <= bit_cnt_d;
      stop_cnt_q <= stop_cnt_d;
      shift_q    <= shift_d;
      tx_q       <= tx_d;
`ifdef UART_TX_PARITY_EN
      parity_q   <= parity_d;
`endif
    end
  end

endmodule

// File: tb/tb_uart_fifo_tx.sv
// Directed testbench for uart_fifo_tx (CLOCKS_PER_BIT=4, DATA_WIDTH=8).
module tb_uart_fifo_tx;

`ifdef UART_TX_PARITY_EN
  localparam int P = 1;
`else
  localparam int P = 0;
`endif
  localparam int CPB = 4;
  localparam int F1  = (1 + 8 + P + 1) * CPB;  // frame cycles, one stop bit
  localparam int F2  = (1 + 8 + P + 2) * CPB;  // frame cycles, two stop bits

  logic       clk = 1'b0;
  logic       reset_n = 1'b0;
  logic       tx_enable = 1'b0;

  // DUT with one stop bit and its FIFO model
  logic       fifo_empty, fifo_read_en, tx, tx_busy;
  logic [7:0] fifo_data;
  logic [7:0] mem [0:15];
  logic [3:0] wr_ptr = '0;
  logic [3:0] rd_ptr = '0;

  // DUT with two stop bits and its FIFO model
  logic       fifo_empty2, fifo_read_en2, tx2, tx_busy2;
  logic [7:0] fifo_data2;
  logic [7:0] mem2 [0:15];
  logic [3:0] wr_ptr2 = '0;
  logic [3:0] rd_ptr2 = '0;

  logic tr_tx   [0:127];
  logic tr_busy [0:127];
  logic tr_re   [0:127];

  int n_cmp = 0;
  int n_err = 0;

  always #5 clk = ~clk;

  assign fifo_empty  = (wr_ptr == rd_ptr);
  assign fifo_data   = mem[rd_ptr];
  assign fifo_empty2 = (wr_ptr2 == rd_ptr2);
  assign fifo_data2  = mem2[rd_ptr2];

  always @(posedge clk) begin
    if (fifo_read_en)  rd_ptr  <= rd_ptr + 4'd1;
    if (fifo_read_en2) rd_ptr2 <= rd_ptr2 + 4'd1;
  end

  uart_fifo_tx #(.DATA_WIDTH(8), .CLOCKS_PER_BIT(CPB), .STOP_BITS(1)) dut (
    .clk(clk), .reset_n(reset_n), .fifo_empty(fifo_empty), .fifo_data(fifo_data),
    .fifo_read_en(fifo_read_en), .tx_enable(tx_enable), .tx(tx), .tx_busy(tx_busy)
  );

  uart_fifo_tx #(.DATA_WIDTH(8), .CLOCKS_PER_BIT(CPB), .STOP_BITS(2)) dut2 (
    .clk(clk), .reset_n(reset_n), .fifo_empty(fifo_empty2), .fifo_data(fifo_data2),
    .fifo_read_en(fifo_read_en2), .tx_enable(tx_enable), .tx(tx2), .tx_busy(tx_busy2)
  );

  task automatic push(input logic [7:0] d);
    mem[wr_ptr] = d;
    wr_ptr = wr_ptr + 4'd1;
  endtask

  task automatic push2(input logic [7:0] d);
    mem2[wr_ptr2] = d;
    wr_ptr2 = wr_ptr2 + 4'd1;
  endtask

  // Records n consecutive negedge samples of the selected DUT's outputs.
  task automatic capture(input int sel, input int n);
    for (int i = 0; i < n; i++) begin
      @(negedge clk);
      tr_tx[i]   = (sel == 0) ? tx : tx2;
      tr_busy[i] = (sel == 0) ? tx_busy : tx_busy2;
      tr_re[i]   = (sel == 0) ? fifo_read_en : fifo_read_en2;
    end
  endtask

  task automatic test_reset;
    @(negedge clk);
    n_cmp++; if (tx !== 1'b1)           begin n_err++; $display("FAIL reset_tx got=%b exp=1", tx); end
    n_cmp++; if (tx_busy !== 1'b0)      begin n_err++; $display("FAIL reset_busy got=%b exp=0", tx_busy); end
    n_cmp++; if (fifo_read_en !== 1'b0) begin n_err++; $display("FAIL reset_read_en got=%b exp=0", fifo_read_en); end
    @(posedge clk); #1 reset_n = 1'b1;
    repeat (2) @(posedge clk);
    #1;
  endtask

  task automatic test_single;
    logic [11:0] fr;
    int pulses, busy_cnt;
`ifdef UART_TX_PARITY_EN
    fr = {1'b0, 1'b1, 1'b0, 8'hA5, 1'b0};
`else
    fr = {2'b00, 1'b1, 8'hA5, 1'b0};
`endif
    @(posedge clk); #1;
    push(8'hA5);
    tx_enable = 1'b1;
    capture(0, F1 + 10);
    pulses = 0; busy_cnt = 0;
    for (int i = 0; i < F1 + 10; i++) begin
      if (tr_re[i] === 1'b1) pulses++;
      if (tr_busy[i] === 1'b1) busy_cnt++;
    end
    n_cmp++; if (tr_re[0] !== 1'b1) begin n_err++; $display("FAIL single_pop_cycle got=%b exp=1", tr_re[0]); end
    n_cmp++; if (pulses != 1)       begin n_err++; $display("FAIL single_pop_count got=%0d exp=1", pulses); end
    n_cmp++; if (busy_cnt != F1)    begin n_err++; $display("FAIL single_busy_len got=%0d exp=%0d", busy_cnt, F1); end
    n_cmp++; if (tr_busy[F1 + 1] !== 1'b0) begin n_err++; $display("FAIL single_busy_end got=%b exp=0", tr_busy[F1 + 1]); end
    for (int i = 1; i <= F1; i++) begin
      n_cmp++;
      if (tr_tx[i] !== fr[(i - 1) / CPB]) begin
        n_err++; $display("FAIL single_tx cyc=%0d got=%b exp=%b", i, tr_tx[i], fr[(i - 1) / CPB]);
      end
    end
    n_cmp++; if (tr_tx[F1 + 1] !== 1'b1) begin n_err++; $display("FAIL single_idle_tx got=%b exp=1", tr_tx[F1 + 1]); end
  endtask

  task automatic test_back_to_back;
    int pulses, busy_cnt;
    @(posedge clk); #1;
    push(8'h00);
    push(8'hFF);
    capture(0, 2 * F1 + 8);
    pulses = 0; busy_cnt = 0;
    for (int i = 0; i < 2 * F1 + 8; i++) begin
      if (tr_re[i] === 1'b1) pulses++;
    end
    for (int i = 1; i <= 2 * F1; i++) begin
      if (tr_busy[i] === 1'b1) busy_cnt++;
    end
    n_cmp++; if (pulses != 2)          begin n_err++; $display("FAIL b2b_pop_count got=%0d exp=2", pulses); end
    n_cmp++; if (tr_re[0] !== 1'b1)    begin n_err++; $display("FAIL b2b_pop1 got=%b exp=1", tr_re[0]); end
    n_cmp++; if (tr_re[F1] !== 1'b1)   begin n_err++; $display("FAIL b2b_pop2 got=%b exp=1", tr_re[F1]); end
    n_cmp++; if (busy_cnt != 2 * F1)   begin n_err++; $display("FAIL b2b_busy_len got=%0d exp=%0d", busy_cnt, 2 * F1); end
    n_cmp++; if (tr_busy[2 * F1 + 1] !== 1'b0) begin n_err++; $display("FAIL b2b_busy_end got=%b exp=0", tr_busy[2 * F1 + 1]); end
    n_cmp++; if (tr_tx[5] !== 1'b0)      begin n_err++; $display("FAIL b2b_f1_data got=%b exp=0", tr_tx[5]); end
    n_cmp++; if (tr_tx[F1] !== 1'b1)     begin n_err++; $display("FAIL b2b_f1_stop got=%b exp=1", tr_tx[F1]); end
    n_cmp++; if (tr_tx[F1 + 1] !== 1'b0) begin n_err++; $display("FAIL b2b_f2_start got=%b exp=0", tr_tx[F1 + 1]); end
    n_cmp++; if (tr_tx[F1 + 5] !== 1'b1) begin n_err++; $display("FAIL b2b_f2_data got=%b exp=1", tr_tx[F1 + 5]); end
  endtask

  task automatic test_enable_gate;
    int bad, busy_cnt, pulses;
    @(posedge clk); #1;
    tx_enable = 1'b0;
    push(8'h5A);
    capture(0, 20);
    bad = 0;
    for (int i = 0; i < 20; i++) begin
      if (tr_re[i] !== 1'b0 || tr_tx[i] !== 1'b1 || tr_busy[i] !== 1'b0) bad++;
    end
    n_cmp++; if (bad != 0) begin n_err++; $display("FAIL gate_hold bad_cycles=%0d exp=0", bad); end
    @(posedge clk); #1 tx_enable = 1'b1;
    @(negedge clk);
    n_cmp++; if (fifo_read_en !== 1'b1) begin n_err++; $display("FAIL gate_pop_same got=%b exp=1", fifo_read_en); end
    n_cmp++; if (tx !== 1'b1)           begin n_err++; $display("FAIL gate_tx_pop_cycle got=%b exp=1", tx); end
    // Dropping enable mid-frame must not truncate it, only hold off the next pop.
    @(posedge clk); #1;
    tx_enable = 1'b0;
    push(8'h11);
    capture(0, F1 + 8);
    busy_cnt = 0; pulses = 0;
    for (int i = 0; i < F1 + 8; i++) begin
      if (tr_busy[i] === 1'b1) busy_cnt++;
      if (tr_re[i] === 1'b1) pulses++;
    end
    n_cmp++; if (tr_tx[0] !== 1'b0)  begin n_err++; $display("FAIL gate_tx_fall got=%b exp=0", tr_tx[0]); end
    n_cmp++; if (busy_cnt != F1)     begin n_err++; $display("FAIL gate_frame_len got=%0d exp=%0d", busy_cnt, F1); end
    n_cmp++; if (pulses != 0)        begin n_err++; $display("FAIL gate_no_pop got=%0d exp=0", pulses); end
    @(posedge clk); #1 tx_enable = 1'b1;
    capture(0, F1 + 4);
    n_cmp++; if (tr_re[0] !== 1'b1)  begin n_err++; $display("FAIL gate_resume got=%b exp=1", tr_re[0]); end
  endtask

  task automatic test_word_07;
    logic [11:0] fr;
    int busy_cnt;
`ifdef UART_TX_PARITY_EN
    fr = {1'b0, 1'b1, 1'b1, 8'h07, 1'b0};
`else
    fr = {2'b00, 1'b1, 8'h07, 1'b0};
`endif
    @(posedge clk); #1;
    push(8'h07);
    capture(0, F1 + 6);
    busy_cnt = 0;
    for (int i = 0; i < F1 + 6; i++) if (tr_busy[i] === 1'b1) busy_cnt++;
    n_cmp++; if (busy_cnt != F1) begin n_err++; $display("FAIL w07_frame_len got=%0d exp=%0d", busy_cnt, F1); end
    for (int b = 0; b < 10 + P; b++) begin
      n_cmp++;
      if (tr_tx[1 + b * CPB + 1] !== fr[b]) begin
        n_err++; $display("FAIL w07_bit b=%0d got=%b exp=%b", b, tr_tx[1 + b * CPB + 1], fr[b]);
      end
    end
  endtask

  task automatic test_reset_mid;
    logic [11:0] fr;
    int busy_cnt;
`ifdef UART_TX_PARITY_EN
    fr = {1'b0, 1'b1, 1'b0, 8'hC3, 1'b0};
`else
    fr = {2'b00, 1'b1, 8'hC3, 1'b0};
`endif
    @(posedge clk); #1;
    push(8'h33);
    push(8'hC3);
    capture(0, 19);  // index 18 lies inside data bit 3
    n_cmp++; if (tr_tx[18] !== 1'b0) begin n_err++; $display("FAIL rst_bit3_level got=%b exp=0", tr_tx[18]); end
    reset_n = 1'b0;
    #1;
    n_cmp++; if (tx !== 1'b1)           begin n_err++; $display("FAIL rst_mid_tx got=%b exp=1", tx); end
    n_cmp++; if (tx_busy !== 1'b0)      begin n_err++; $display("FAIL rst_mid_busy got=%b exp=0", tx_busy); end
    n_cmp++; if (fifo_read_en !== 1'b0) begin n_err++; $display("FAIL rst_mid_read_en got=%b exp=0", fifo_read_en); end
    @(posedge clk); #1;
    @(posedge clk); #1 reset_n = 1'b1;
    capture(0, F1 + 6);
    busy_cnt = 0;
    for (int i = 0; i < F1 + 6; i++) if (tr_busy[i] === 1'b1) busy_cnt++;
    n_cmp++; if (tr_re[0] !== 1'b1) begin n_err++; $display("FAIL rst_repop got=%b exp=1", tr_re[0]); end
    n_cmp++; if (busy_cnt != F1)    begin n_err++; $display("FAIL rst_frame_len got=%0d exp=%0d", busy_cnt, F1); end
    for (int b = 0; b < 10 + P; b++) begin
      n_cmp++;
      if (tr_tx[1 + b * CPB + 2] !== fr[b]) begin
        n_err++; $display("FAIL rst_next_bit b=%0d got=%b exp=%b", b, tr_tx[1 + b * CPB + 2], fr[b]);
      end
    end
  endtask

  task automatic test_two_stop;
    logic [11:0] fr;
    int busy_cnt, pulses;
`ifdef UART_TX_PARITY_EN
    fr = {2'b11, 1'b0, 8'h3C, 1'b0};
`else
    fr = {1'b0, 2'b11, 8'h3C, 1'b0};
`endif
    @(posedge clk); #1;
    push2(8'h3C);
    capture(1, F2 + 6);
    busy_cnt = 0; pulses = 0;
    for (int i = 0; i < F2 + 6; i++) begin
      if (tr_busy[i] === 1'b1) busy_cnt++;
      if (tr_re[i] === 1'b1) pulses++;
    end
    n_cmp++; if (busy_cnt != F2) begin n_err++; $display("FAIL stop2_frame_len got=%0d exp=%0d", busy_cnt, F2); end
    n_cmp++; if (pulses != 1)    begin n_err++; $display("FAIL stop2_pop_count got=%0d exp=1", pulses); end
    n_cmp++; if (tr_tx[F2 - 8] !== 1'b0) begin n_err++; $display("FAIL stop2_pre_stop got=%b exp=0", tr_tx[F2 - 8]); end
    for (int i = 1; i <= F2; i++) begin
      n_cmp++;
      if (tr_tx[i] !== fr[(i - 1) / CPB]) begin
        n_err++; $display("FAIL stop2_tx cyc=%0d got=%b exp=%b", i, tr_tx[i], fr[(i - 1) / CPB]);
      end
    end
  endtask

  initial begin
    test_reset;
    test_single;
    test_back_to_back;
    test_enable_gate;
    test_word_07;
    test_reset_mid;
    test_two_stop;
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
